ahb_bus_arbiter: RTL



---
 rtl/ahb_bus_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: one-hot HGRANT plus HMASTER/HMASTLOCK, all state stepped only on HREADY=1 edges.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin; the default build uses fixed priority (lowest index >= 1).
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_HOLD       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_MASTERS-1:0]         HBUSREQ,
    input  logic [NUM_MASTERS-1:0]         HLOCK,
    input  logic [1:0]                     HTRANS,
    input  logic                           HREADY,
    output logic [NUM_MASTERS-1:0]         HGRANT,
    output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
    output logic                           HMASTLOCK
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);
    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    typedef enum logic [1:0] {
        ST_DEFAULT = 2'd0,
        ST_OWNED   = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [MW-1:0]           grant_q, grant_d;
    logic [NUM_MASTERS-1:0]  hgrant_q, hgrant_d;
    logic [CW-1:0]           hold_q, hold_d;
    logic [MW-1:0]           hmaster_q;
    logic                    hmastlock_q;

    logic [NUM_MASTERS-1:0]  cand, others;
    logic                    hold_max, owner_req, owner_lock, burst, found;
    logic [MW-1:0]           win;

`ifdef ARB_ROUND_ROBIN_EN
    logic [MW-1:0]           ptr_q, ptr_d;
`endif

    always_comb begin
        cand       = HBUSREQ;
        cand[0]    = 1'b0;
        others     = cand;
        others[grant_q] = 1'b0;
        hold_max   = (hold_q == CW'(MAX_HOLD));
        owner_req  = HBUSREQ[grant_q];
        owner_lock = HLOCK[grant_q];
        burst      = (HTRANS == TR_SEQ) || (HTRANS == TR_BUSY);
        found      = 1'b0;
        win        = DEF;
        grant_d    = grant_q;
        state_d    = state_q;
        hold_d     = hold_q;
        hgrant_d   = '0;

        // A hold-counter expiry hands the bus away from the owner when anyone else wants it.
        if (hold_max && (|others)) begin
            cand = others;
        end

`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            int j;
            j = (int'(ptr_q) + i) % NUM_MASTERS;
            if (!found && cand[MW'(j)]) begin
                found = 1'b1;
                win   = MW'(j);
            end
        end
`else
        for (int i = NUM_MASTERS - 1; i >= 1; i--) begin
            if (cand[MW'(i)]) begin
                found = 1'b1;
                win   = MW'(i);
            end
        end
`endif

        if ((grant_q != DEF) && owner_req && owner_lock) begin
            state_d = ST_LOCKED;
        end else begin
            if (!burst && (!owner_req || (grant_q == DEF) || hold_max)) begin
                grant_d = found ? win : DEF;
            end
            state_d = (grant_d == DEF) ? ST_DEFAULT : ST_OWNED;
        end

        if ((grant_d != grant_q) || (state_q != ST_OWNED)) begin
            hold_d = '0;
        end else if ((|others) && !hold_max) begin
            hold_d = hold_q + CW'(1);
        end

        hgrant_d[grant_d] = 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
        ptr_d = ((grant_d != grant_q) && (grant_d != DEF)) ? grant_d : ptr_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_DEFAULT;
            grant_q     <= DEF;
            hgrant_q    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
            hold_q      <= '0;
            hmaster_q   <= DEF;
            hmastlock_q <= 1'b0;
        end else if (HREADY) begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            hgrant_q    <= hgrant_d;
            hold_q      <= hold_d;
            hmaster_q   <= grant_q;
            hmastlock_q <= (state_q == ST_LOCKED);
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= DEF;
        end else if (HREADY) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;
endmodule
